// File: rtl/tomasulo_reg_status_file.sv
// tomasulo_reg_status_file: register file with per-register producer tags, CDB writeback/bypass, rename and flush
module tomasulo_reg_status_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int TAG_W    = 4,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 0
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  ren_en,
  input  logic [IDX_W-1:0]      ren_reg,
  input  logic [TAG_W-1:0]      ren_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_W-1:0]     cdb_data,
  input  logic                  flush,
  input  logic [NRD*IDX_W-1:0]  rd_num,
  output logic [NRD*TAG_W-1:0]  rd_tag,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [IDX_W:0]        pending_cnt
);
  logic [DATA_W-1:0] rf     [NUM_REGS];
  logic [TAG_W-1:0]  tag    [NUM_REGS];
  logic [DATA_W-1:0] rf_n   [NUM_REGS];
  logic [TAG_W-1:0]  tag_n  [NUM_REGS];
  logic [IDX_W:0]    cnt_n;
  logic [NRD-1:0]    byp;
  logic [NRD*TAG_W-1:0]  rt_n;
  logic [NRD*DATA_W-1:0] rdat_n;
  logic cdb_hit;

  assign cdb_hit = cdb_valid && cdb_tag != '0;

  // next state: CDB match writes data and clears tag, rename wins the tag, flush clears every tag
  always_comb begin
    cnt_n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_n[i]  = (cdb_hit && tag[i] == cdb_tag) ? cdb_data : rf[i];
      tag_n[i] = flush ? '0 :
                 (ren_en && ren_reg == IDX_W'(i)) ? ren_tag :
                 (cdb_hit && tag[i] == cdb_tag) ? '0 : tag[i];
      if (ZERO_REG && i == 0) begin
        rf_n[i]  = '0;
        tag_n[i] = '0;
      end
      cnt_n = cnt_n + (IDX_W+1)'(tag_n[i] != '0);
    end
  end

  // read ports on pre-edge state, with bypass when the CDB is delivering the awaited tag
  always_comb begin
    rt_n   = '0;
    rdat_n = '0;
    byp    = '0;
    for (int k = 0; k < NRD; k++) begin
      byp[k] = cdb_valid && tag[rd_num[k*IDX_W +: IDX_W]] != '0 &&
               cdb_tag == tag[rd_num[k*IDX_W +: IDX_W]];
      rt_n[k*TAG_W +: TAG_W]    = byp[k] ? '0 : tag[rd_num[k*IDX_W +: IDX_W]];
      rdat_n[k*DATA_W +: DATA_W] = byp[k] ? cdb_data : rf[rd_num[k*IDX_W +: IDX_W]];
    end
  end

  // state and registered outputs; reset loads reg[i] = i+1 with no producers
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i]  <= (ZERO_REG && i == 0) ? '0 : DATA_W'(i + 1);
        tag[i] <= '0;
      end
      rd_tag      <= '0;
      rd_data     <= '0;
      pending_cnt <= '0;
    end else begin
      rf          <= rf_n;
      tag         <= tag_n;
      rd_tag      <= rt_n;
      rd_data     <= rdat_n;
      pending_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_tomasulo_reg_status_file.sv
// tb_tomasulo_reg_status_file: scoreboard bench for the register status file (default and ZERO_REG builds)
module tb_tomasulo_reg_status_file;
  logic CLK = 0;
  logic CLR = 0;
  logic ren_en = 0, cdb_valid = 0, flush = 0;
  logic [2:0] ren_reg = 0;
  logic [3:0] ren_tag = 0, cdb_tag = 0;
  logic [15:0] cdb_data = 0;
  logic [5:0] rd_num = 0;
  logic [7:0] rd_tag;
  logic [31:0] rd_data;
  logic [3:0] pending_cnt;
  logic z_ren_en = 0, z_cdb_valid = 0, z_flush = 0;
  logic [2:0] z_ren_reg = 0;
  logic [3:0] z_ren_tag = 0, z_cdb_tag = 0;
  logic [15:0] z_cdb_data = 0;
  logic [5:0] z_rd_num = 0;
  logic [7:0] z_rd_tag;
  logic [31:0] z_rd_data;
  logic [3:0] z_pending_cnt;
  logic [43:0] exp_q [$];
  logic [43:0] obs_q [$];
  logic [43:0] e, o;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  tomasulo_reg_status_file dut (
    .CLK(CLK), .CLR(CLR), .ren_en(ren_en), .ren_reg(ren_reg), .ren_tag(ren_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .rd_num(rd_num), .rd_tag(rd_tag), .rd_data(rd_data), .pending_cnt(pending_cnt)
  );

  tomasulo_reg_status_file #(.ZERO_REG(1)) dut_z (
    .CLK(CLK), .CLR(CLR), .ren_en(z_ren_en), .ren_reg(z_ren_reg), .ren_tag(z_ren_tag),
    .cdb_valid(z_cdb_valid), .cdb_tag(z_cdb_tag), .cdb_data(z_cdb_data), .flush(z_flush),
    .rd_num(z_rd_num), .rd_tag(z_rd_tag), .rd_data(z_rd_data), .pending_cnt(z_pending_cnt)
  );

  function automatic logic [43:0] mk(input int t0, input int d0, input int t1, input int d1, input int c);
    return {4'(t1), 4'(t0), 16'(d1), 16'(d0), 4'(c)};
  endfunction

  task automatic cyc(input bit z, input bit re, input int rr, input int rt, input bit cv, input int ct,
                     input int cd, input bit fl, input int p0, input int p1, input logic [43:0] ex);
    if (z) begin
      z_ren_en = re; z_ren_reg = 3'(rr); z_ren_tag = 4'(rt);
      z_cdb_valid = cv; z_cdb_tag = 4'(ct); z_cdb_data = 16'(cd);
      z_flush = fl; z_rd_num = {3'(p1), 3'(p0)};
    end else begin
      ren_en = re; ren_reg = 3'(rr); ren_tag = 4'(rt);
      cdb_valid = cv; cdb_tag = 4'(ct); cdb_data = 16'(cd);
      flush = fl; rd_num = {3'(p1), 3'(p0)};
    end
    exp_q.push_back(ex);
    @(posedge CLK);
    #1;
    obs_q.push_back(z ? {z_rd_tag, z_rd_data, z_pending_cnt} : {rd_tag, rd_data, pending_cnt});
    {ren_en, cdb_valid, flush, z_ren_en, z_cdb_valid, z_flush} = '0;
  endtask

  task automatic test_reset;
    int k = 0;
    CLR = 1;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    obs_q.push_back({rd_tag, rd_data, pending_cnt});
    @(posedge CLK);
    #1;
    CLR = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, mk(0, 4, 0, 8, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset[%0d] got=%h want=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_rename_writeback;
    int k = 0;
    cyc(0, 1, 2, 5, 0, 0, 0, 0, 2, 2, mk(0, 3, 0, 3, 1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, mk(5, 3, 5, 3, 1));
    cyc(0, 0, 0, 0, 1, 5, 'hBEEF, 0, 2, 2, mk(0, 'hBEEF, 0, 'hBEEF, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, mk(0, 'hBEEF, 0, 'hBEEF, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rename_wb[%0d] got=%h want=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_waw;
    int k = 0;
    cyc(0, 1, 4, 3, 0, 0, 0, 0, 4, 4, mk(0, 5, 0, 5, 1));
    cyc(0, 1, 4, 6, 0, 0, 0, 0, 4, 4, mk(3, 5, 3, 5, 1));
    cyc(0, 0, 0, 0, 1, 3, 'h1111, 0, 4, 4, mk(6, 5, 6, 5, 1));
    cyc(0, 0, 0, 0, 1, 6, 'h2222, 0, 4, 0, mk(0, 'h2222, 0, 1, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 4, 4, mk(0, 'h2222, 0, 'h2222, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL waw[%0d] got=%h want=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_bypass_collision;
    int k = 0;
    cyc(0, 1, 1, 9, 0, 0, 0, 0, 1, 3, mk(0, 2, 0, 4, 1));
    cyc(0, 1, 1, 2, 1, 9, 'h00AA, 0, 1, 1, mk(0, 'h00AA, 0, 'h00AA, 1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, mk(2, 'h00AA, 2, 'h00AA, 1));
    cyc(0, 0, 0, 0, 1, 2, 'h1234, 0, 1, 5, mk(0, 'h1234, 0, 6, 0));
    cyc(0, 0, 0, 0, 1, 0, 'hDEAD, 0, 1, 0, mk(0, 'h1234, 0, 1, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL bypass[%0d] got=%h want=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_multi_match_flush;
    int k = 0;
    cyc(0, 1, 5, 7, 0, 0, 0, 0, 5, 6, mk(0, 6, 0, 7, 1));
    cyc(0, 1, 6, 7, 0, 0, 0, 0, 5, 6, mk(7, 6, 0, 7, 2));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 6, mk(7, 6, 7, 7, 2));
    cyc(0, 0, 0, 0, 1, 7, 'h0042, 0, 5, 6, mk(0, 'h0042, 0, 'h0042, 0));
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 3, mk(0, 1, 0, 4, 1));
    cyc(0, 1, 1, 2, 0, 0, 0, 0, 0, 3, mk(1, 1, 0, 4, 2));
    cyc(0, 1, 2, 3, 0, 0, 0, 0, 1, 2, mk(2, 'h1234, 0, 'hBEEF, 3));
    cyc(0, 1, 3, 4, 0, 0, 0, 0, 3, 0, mk(0, 4, 1, 1, 4));
    cyc(0, 1, 7, 5, 1, 3, 'h5555, 1, 2, 3, mk(0, 'h5555, 4, 4, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 1, 0, 'h1234, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, 3, mk(0, 'h5555, 0, 4, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, mk(0, 8, 0, 8, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL multi_flush[%0d] got=%h want=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_zero_reg;
    int k = 0;
    cyc(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 1, 4, 'h7777, 0, 0, 0, mk(0, 0, 0, 0, 0));
    cyc(1, 1, 3, 4, 0, 0, 0, 0, 0, 3, mk(0, 0, 0, 4, 1));
    cyc(1, 0, 0, 0, 1, 4, 'h9999, 0, 0, 3, mk(0, 0, 0, 'h9999, 0));
    cyc(1, 1, 6, 2, 0, 0, 0, 0, 3, 0, mk(0, 'h9999, 0, 0, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL zero_reg[%0d] got=%h want=%h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_reset_midop;
    int k = 0;
    cyc(0, 1, 5, 3, 0, 0, 0, 0, 5, 2, mk(0, 'h0042, 0, 'h5555, 1));
    ren_en = 1; ren_reg = 3'd4; ren_tag = 4'd9;
    z_ren_en = 1; z_ren_reg = 3'd1; z_ren_tag = 4'd5;
    CLR = 1;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    obs_q.push_back({rd_tag, rd_data, pending_cnt});
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    obs_q.push_back({z_rd_tag, z_rd_data, z_pending_cnt});
    @(posedge CLK);
    #1;
    {ren_en, z_ren_en} = '0;
    CLR = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 2, mk(0, 6, 0, 3, 0));
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 3, 6, mk(0, 4, 0, 7, 0));
    cyc(0, 1, 4, 2, 0, 0, 0, 0, 4, 1, mk(0, 5, 0, 2, 1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 4, 4, mk(2, 5, 2, 5, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_midop[%0d] got=%h want=%h", k, o, e); end
      k++;
    end
  endtask

  initial begin
    test_reset;
    test_rename_writeback;
    test_waw;
    test_bypass_collision;
    test_multi_match_flush;
    test_zero_reg;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tomasulo_reg_status_file.md
Name: tomasulo_reg_status_file

Overview:
- Parametrised architectural register file with per-register producer-tag (Qi) status for the Tomasulo core.
- Supports N registered read ports with same-cycle CDB bypass, and a rename port used at issue.
- Writeback is tag-matched from CDB snooping, with no explicit write index.
- Also provides a global tag flush and a live count of pending registers for the issue stall logic.

Parameters:
DATA_W, 16, data width of each register
NUM_REGS, 8, number of architectural registers (power of two, >=2)
IDX_W, $clog2(NUM_REGS), register index width (derived, do not override)
TAG_W, 4, reservation-station tag width; tag 0 = "no producer"
NRD, 2, number of read ports
ZERO_REG, 0, 1 = register 0 reads as 0, never renamed or written

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  reset, asynchronous, active-high
ren_en  in  1  rename strobe: assign producer tag to destination register
ren_reg  in  IDX_W  destination register index
ren_tag  in  TAG_W  producing station tag (nonzero)
cdb_valid  in  1  common data bus broadcast valid
cdb_tag  in  TAG_W  tag of broadcasting station
cdb_data  in  DATA_W  broadcast result
flush  in  1  synchronous clear of all tags (data kept)
rd_num  in  NRD*IDX_W  read indices, port k at [k*IDX_W +: IDX_W]
rd_tag  out  NRD*TAG_W  registered producer tag per port, 0 = data valid
rd_data  out  NRD*DATA_W  registered data per port
pending_cnt  out  IDX_W+1  number of registers with nonzero tag

Behaviour:
- Reset (CLR high, async): reg[i] = i+1 for all i (reg0 = 0 when ZERO_REG=1); all tags = 0; rd_tag = 0; rd_data = 0; pending_cnt = 0.
- All updates happen on the rising edge of CLK. Reads have 1-cycle latency: rd_* at edge t+1 reflect rd_num sampled at edge t.
- CDB writeback: if cdb_valid and cdb_tag != 0, every register i with tag[i] == cdb_tag gets reg[i] <= cdb_data and tag[i] <= 0. Registers whose tag differs are untouched; this handles WAW correctly.
- cdb_valid with cdb_tag == 0 is ignored.
- Rename: if ren_en, tag[ren_reg] <= ren_tag. ren_tag == 0 is a protocol error; the block treats it as a tag clear.
- Same register, same cycle, CDB match and rename: data <= cdb_data and tag <= ren_tag. Rename wins the tag.
- Read port k, evaluated on pre-edge state:
  - If tag[rd_num_k] != 0 and cdb_valid and cdb_tag == tag[rd_num_k]: rd_tag_k <= 0 and rd_data_k <= cdb_data (bypass).
  - Otherwise: rd_tag_k <= tag[rd_num_k] and rd_data_k <= reg[rd_num_k].
- Reads never see the same-cycle rename. An instruction's sources read old state before its destination is renamed.
- Multiple ports may read the same index; each receives identical values.
- flush: all tags <= 0 and reg contents unchanged. It takes priority over rename and over CDB tag effects.
  - A CDB data write in the flush cycle still updates data for matching registers.
  - Read outputs in the flush cycle follow the normal rule on pre-edge state.
- ZERO_REG=1: rename and CDB writes to index 0 are dropped; reads of index 0 return tag 0 and data 0.
- pending_cnt: registered and equal to the popcount of tags after the edge. It updates in the same edge as the tag change, and is 0 after flush.
- Reset asserted mid-operation clears everything immediately. The first edge after CLR deasserts behaves normally.

Test Plan:
- Reset: pulse CLR, then read indices 3 and 7 -> rd_data = 4, 8; rd_tag = 0, 0; pending_cnt = 0.
- Rename then writeback: ren r2 tag 5; next cycle read r2 -> rd_tag = 5. Then CDB tag 5 data 0xBEEF -> the following read of r2 gives tag 0, data 0xBEEF; pending_cnt goes 1 -> 0.
- WAW: ren r4 tag 3, then ren r4 tag 6; CDB tag 3 data 0x1111 -> r4 stays tag 6 with old data. CDB tag 6 data 0x2222 -> r4 = 0x2222, tag 0.
- Bypass and collision:
  - r1 has tag 9; read r1 on port 0 in the same cycle as CDB tag 9 data 0x00AA -> rd_tag0 = 0, rd_data0 = 0x00AA next edge.
  - In the same cycle, ren r1 tag 2 -> r1 data = 0x00AA, tag = 2.
- Multi-match and flush:
  - r5 and r6 both tag 7; CDB tag 7 data 0x0042 -> both updated, pending_cnt decreases by 2.
  - Rename r0..r3, then flush -> pending_cnt = 0, all rd_tag = 0, data preserved.
- ZERO_REG=1 build: ren r0 tag 4 and CDB writes to r0 -> r0 always reads 0 with tag 0. Also assert CLR mid-rename -> all state returns to reset values.
